// File: rtl/toggle_port_responder.sv
// ---------------------------------------------------------------------------------------------
// toggle_port_responder
//
// Responder side of the toggle request/acknowledge port used by the ROM download path for the
// SDRAM ports. Every transition of port_req is one request. Each request is latched into a small
// FIFO together with its address, strobes, direction and write data. The requests are then
// replayed in order to a valid/ready memory backend. port_ack flips once for every request that
// either completes at the backend or is dropped because the FIFO was full.
//
// Parameters
//   AW    : word address width (port_a, mem_addr)
//   DW    : data width (port_d, port_q, mem_wdata, mem_rdata)
//   DEPTH : request FIFO entries; must be a power of two and at least 2
//
// Ports
//   clk        in   single clock, everything is synchronous to it
//   reset      in   synchronous, active-high
//   port_req   in   request toggle
//   port_ack   out  acknowledge toggle; equals port_req when nothing is outstanding
//   port_a     in   word address, sampled in the cycle port_req transitions
//   port_ds    in   byte lane strobes {hi, lo}
//   port_we    in   1 = write, 0 = read
//   port_d     in   write data
//   port_q     out  data returned by the most recent read
//   mem_valid  out  backend command valid
//   mem_ready  in   backend accepts the command when mem_valid && mem_ready
//   mem_addr   out  command address
//   mem_we     out  command is a write
//   mem_be     out  byte enables (copy of port_ds)
//   mem_wdata  out  command write data
//   mem_rvalid in   read data strobe, only honoured while waiting for read data
//   mem_rdata  in   read data
//   overflow   out  sticky flag: at least one request was dropped
// ---------------------------------------------------------------------------------------------

module toggle_port_responder #(
  parameter int unsigned AW    = 23,
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          port_req,
  output logic          port_ack,
  input  logic [AW-1:0] port_a,
  input  logic [1:0]    port_ds,
  input  logic          port_we,
  input  logic [DW-1:0] port_d,
  output logic [DW-1:0] port_q,

  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [1:0]    mem_be,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,

  output logic          overflow
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  // FSM encoding kept as plain constants for compatibility with existing tooling.
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StIssue  = 2'd1;
  localparam logic [1:0] StRdWait = 2'd2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    be;
    logic          we;
    logic [DW-1:0] wdata;
  } cmd_t;

  // -------------------------------------------------------------------------------------------
  // Request edge detection
  // -------------------------------------------------------------------------------------------
  logic req_q;
  logic req_edge;

  assign req_edge = port_req ^ req_q;

  // -------------------------------------------------------------------------------------------
  // Request FIFO
  // -------------------------------------------------------------------------------------------
  cmd_t            fifo_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic            drop;
  cmd_t            push_entry;
  cmd_t            head_entry;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FullCount);

  assign push_entry = '{addr: port_a, be: port_ds, we: port_we, wdata: port_d};
  assign head_entry = fifo_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO only fails without one.
  assign push = req_edge && (!fifo_full || pop);
  assign drop = req_edge && fifo_full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; occupancy is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= push_entry;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Command sequencer
  // -------------------------------------------------------------------------------------------
  logic [1:0]    state_q, state_d;
  logic          mem_valid_q, mem_valid_d;
  cmd_t          cmd_q;
  logic [DW-1:0] port_q_q;
  logic          completion;
  logic          rdata_load;

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    pop         = 1'b0;
    completion  = 1'b0;
    rdata_load  = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          mem_valid_d = 1'b1;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (cmd_q.we) begin
            completion = 1'b1;
            state_d    = StIdle;
          end else begin
            state_d    = StRdWait;
          end
        end
      end
      StRdWait: begin
        if (mem_rvalid) begin
          rdata_load = 1'b1;
          completion = 1'b1;
          state_d    = StIdle;
        end
      end
      default: begin
        mem_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  // -------------------------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------------------------
  logic ack_q;
  logic overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      // Track the current request level so releasing reset never looks like a new request.
      req_q       <= port_req;
      ack_q       <= port_req;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= StIdle;
      mem_valid_q <= 1'b0;
      cmd_q       <= '0;
      port_q_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      req_q       <= port_req;
      // A completion and a drop in the same cycle cancel out in the toggle parity.
      ack_q       <= ack_q ^ (completion ^ drop);
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      if (pop) begin
        cmd_q <= head_entry;
      end
      if (rdata_load) begin
        port_q_q <= mem_rdata;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------------------------
  assign port_ack  = ack_q;
  assign port_q    = port_q_q;
  assign overflow  = overflow_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = cmd_q.addr;
  assign mem_we    = cmd_q.we;
  assign mem_be    = cmd_q.be;
  assign mem_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_toggle_port_responder.sv
module tb_toggle_port_responder;

  localparam int unsigned AW = 23;
  localparam int unsigned DW = 16;

  logic          clk;
  logic          reset;
  logic          port_req;
  logic          port_ack;
  logic [AW-1:0] port_a;
  logic [1:0]    port_ds;
  logic          port_we;
  logic [DW-1:0] port_d;
  logic [DW-1:0] port_q;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [1:0]    mem_be;
  logic [DW-1:0] mem_wdata;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  // {we, addr} of every command the backend accepted, in order.
  logic [AW:0] accepted [$];

  toggle_port_responder #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .port_req   (port_req),
    .port_ack   (port_ack),
    .port_a     (port_a),
    .port_ds    (port_ds),
    .port_we    (port_we),
    .port_d     (port_d),
    .port_q     (port_q),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .overflow   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (!reset && mem_valid && mem_ready) begin
      accepted.push_back({mem_we, mem_addr});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    port_req = 1'b0;
    step();
    step();
    checks++; if (port_ack !== 1'b0) begin failures++; $display("FAIL rst_ack: got %b want 0", port_ack); end
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", mem_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    checks++; if (port_q !== 16'h0000) begin failures++; $display("FAIL rst_q: got %h want 0000", port_q); end
    reset = 1'b0;
    step();
    step();
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL rst_no_cmd: got %b want 0", mem_valid); end
    checks++; if (port_ack !== 1'b0) begin failures++; $display("FAIL rst_ack_hold: got %b want 0", port_ack); end
  endtask

  task automatic test_single_write();
    port_req = 1'b1; port_a = 23'h000123; port_ds = 2'b01; port_we = 1'b1; port_d = 16'hAB12;
    mem_ready = 1'b1;
    step();
    // Scramble the port fields to show the request was latched at the edge.
    port_a = '1; port_ds = 2'b10; port_we = 1'b0; port_d = 16'hFFFF;
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL wr_valid_early: got %b want 0", mem_valid); end
    step();
    checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL wr_valid: got %b want 1", mem_valid); end
    checks++; if (mem_addr !== 23'h000123) begin failures++; $display("FAIL wr_addr: got %h want 000123", mem_addr); end
    checks++; if (mem_be !== 2'b01) begin failures++; $display("FAIL wr_be: got %b want 01", mem_be); end
    checks++; if (mem_wdata !== 16'hAB12) begin failures++; $display("FAIL wr_data: got %h want ab12", mem_wdata); end
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL wr_we: got %b want 1", mem_we); end
    checks++; if (port_ack !== 1'b0) begin failures++; $display("FAIL wr_ack_early: got %b want 0", port_ack); end
    step();
    checks++; if (port_ack !== 1'b1) begin failures++; $display("FAIL wr_ack: got %b want 1", port_ack); end
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL wr_valid_drop: got %b want 0", mem_valid); end
  endtask

  task automatic test_single_read();
    port_req = 1'b0; port_a = 23'h07FFFF; port_ds = 2'b11; port_we = 1'b0; port_d = 16'h0000;
    mem_ready = 1'b1; mem_rvalid = 1'b0;
    step();
    step();
    checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL rd_valid: got %b want 1", mem_valid); end
    checks++; if (mem_addr !== 23'h07FFFF) begin failures++; $display("FAIL rd_addr: got %h want 07ffff", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rd_we: got %b want 0", mem_we); end
    step();  // accepted on this edge
    for (int i = 0; i < 2; i++) begin
      checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL rd_valid_once[%0d]: got %b want 0", i, mem_valid); end
      step();
    end
    mem_rvalid = 1'b1; mem_rdata = 16'h5AA5;
    checks++; if (port_ack !== 1'b1) begin failures++; $display("FAIL rd_ack_early: got %b want 1", port_ack); end
    checks++; if (port_q !== 16'h0000) begin failures++; $display("FAIL rd_q_early: got %h want 0000", port_q); end
    step();
    mem_rvalid = 1'b0;
    checks++; if (port_q !== 16'h5AA5) begin failures++; $display("FAIL rd_q: got %h want 5aa5", port_q); end
    checks++; if (port_ack !== 1'b0) begin failures++; $display("FAIL rd_ack: got %b want 0", port_ack); end
  endtask

  task automatic test_burst();
    int   toggles;
    logic prev;
    logic [AW:0] entry;
    accepted.delete();
    mem_ready = 1'b0;
    toggles = 0;
    prev = port_ack;
    for (int i = 0; i < 4; i++) begin
      port_req = ~port_req; port_a = AW'(i); port_we = 1'b1; port_ds = 2'b11; port_d = DW'(16'h0100 + i);
      step();
      if (port_ack !== prev) toggles++;
      prev = port_ack;
    end
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 23'd0) begin failures++; $display("FAIL burst_head: got valid=%b addr=%h want 1/0", mem_valid, mem_addr); end
    for (int i = 0; i < 6; i++) begin
      step();
      if (port_ack !== prev) toggles++;
      prev = port_ack;
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (port_ack !== prev) toggles++;
      prev = port_ack;
    end
    checks++; if (toggles !== 4) begin failures++; $display("FAIL burst_toggles: got %0d want 4", toggles); end
    checks++; if (port_ack !== port_req) begin failures++; $display("FAIL burst_ack_eq: got %b want %b", port_ack, port_req); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL burst_ovf: got %b want 0", overflow); end
    checks++; if (accepted.size() !== 4) begin failures++; $display("FAIL burst_count: got %0d want 4", accepted.size()); end
    for (int i = 0; i < 4 && i < accepted.size(); i++) begin
      entry = accepted[i];
      checks++; if (entry !== {1'b1, AW'(i)}) begin failures++; $display("FAIL burst_order[%0d]: got %h want %h", i, entry, {1'b1, AW'(i)}); end
    end
  endtask

  task automatic test_overflow();
    int   toggles;
    logic ack0;
    logic prev;
    logic [AW:0] entry;
    accepted.delete();
    mem_ready = 1'b0;
    ack0 = port_ack;
    for (int i = 0; i < 5; i++) begin
      port_req = ~port_req; port_a = AW'(32'h10 + i); port_we = 1'b1; port_d = DW'(i);
      step();
      checks++; if (port_ack !== ack0) begin failures++; $display("FAIL ovf_ack_hold[%0d]: got %b want %b", i, port_ack, ack0); end
    end
    port_req = ~port_req; port_a = 23'h000015;
    step();
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (port_ack !== ~ack0) begin failures++; $display("FAIL ovf_drop_ack: got %b want %b", port_ack, ~ack0); end
    checks++; if (dut.count_q !== 3'd4) begin failures++; $display("FAIL ovf_fifo_count: got %0d want 4", dut.count_q); end
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 23'h000010) begin failures++; $display("FAIL ovf_head: got valid=%b addr=%h want 1/000010", mem_valid, mem_addr); end
    mem_ready = 1'b1;
    toggles = 0;
    prev = port_ack;
    for (int i = 0; i < 30; i++) begin
      step();
      if (port_ack !== prev) toggles++;
      prev = port_ack;
    end
    checks++; if (toggles !== 5) begin failures++; $display("FAIL ovf_drain_toggles: got %0d want 5", toggles); end
    checks++; if (port_ack !== port_req) begin failures++; $display("FAIL ovf_ack_eq: got %b want %b", port_ack, port_req); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    checks++; if (accepted.size() !== 5) begin failures++; $display("FAIL ovf_accepted: got %0d want 5", accepted.size()); end
    for (int i = 0; i < 5 && i < accepted.size(); i++) begin
      entry = accepted[i];
      checks++; if (entry[AW-1:0] !== AW'(32'h10 + i)) begin failures++; $display("FAIL ovf_order[%0d]: got %h want %h", i, entry[AW-1:0], AW'(32'h10 + i)); end
    end
  endtask

  task automatic test_simultaneous();
    int   toggles;
    logic prev;
    reset = 1'b1; port_req = 1'b0;
    step();
    reset = 1'b0;
    accepted.delete();
    mem_ready = 1'b0;
    // Five requests: one held in the sequencer, four fill the FIFO. Entry 1 is a read.
    for (int i = 0; i < 5; i++) begin
      port_req = ~port_req; port_a = AW'(32'h20 + i); port_we = (i != 1); port_d = DW'(i);
      step();
    end
    checks++; if (dut.count_q !== 3'd4) begin failures++; $display("FAIL sim_full: got %0d want 4", dut.count_q); end
    mem_ready = 1'b1;
    step();  // write 0x20 accepted, sequencer back to idle
    checks++; if (port_ack !== 1'b1) begin failures++; $display("FAIL sim_wr_ack: got %b want 1", port_ack); end
    mem_ready = 1'b0;
    port_req = ~port_req; port_a = 23'h000025; port_we = 1'b1;
    step();  // pop and push together while full
    checks++; if (dut.count_q !== 3'd4) begin failures++; $display("FAIL sim_push_pop_count: got %0d want 4", dut.count_q); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL sim_no_drop: got %b want 0", overflow); end
    checks++; if (port_ack !== 1'b1) begin failures++; $display("FAIL sim_ack_still: got %b want 1", port_ack); end
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 23'h000021 || mem_we !== 1'b0) begin failures++; $display("FAIL sim_rd_cmd: got valid=%b addr=%h we=%b want 1/000021/0", mem_valid, mem_addr, mem_we); end
    mem_ready = 1'b1;
    step();  // read accepted, waiting for data
    mem_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 16'hC3C3;
    port_req = ~port_req; port_a = 23'h000026;
    step();  // read completes while a push is dropped
    mem_rvalid = 1'b0;
    checks++; if (port_ack !== 1'b1) begin failures++; $display("FAIL sim_both_ack: got %b want 1", port_ack); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL sim_both_ovf: got %b want 1", overflow); end
    checks++; if (port_q !== 16'hC3C3) begin failures++; $display("FAIL sim_both_q: got %h want c3c3", port_q); end
    checks++; if (dut.count_q !== 3'd4) begin failures++; $display("FAIL sim_both_count: got %0d want 4", dut.count_q); end
    mem_ready = 1'b1;
    toggles = 0;
    prev = port_ack;
    for (int i = 0; i < 20; i++) begin
      step();
      if (port_ack !== prev) toggles++;
      prev = port_ack;
    end
    checks++; if (toggles !== 4) begin failures++; $display("FAIL sim_drain_toggles: got %0d want 4", toggles); end
    checks++; if (port_ack !== port_req) begin failures++; $display("FAIL sim_ack_eq: got %b want %b", port_ack, port_req); end
    checks++; if (accepted.size() !== 6) begin failures++; $display("FAIL sim_accepted: got %0d want 6", accepted.size()); end
  endtask

  task automatic test_reset_mid_read();
    port_req = ~port_req; port_a = 23'h000040; port_we = 1'b0;
    mem_ready = 1'b1;
    step();
    step();
    step();  // read accepted, sequencer waiting for data
    port_req = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    accepted.delete();
    step();
    checks++; if (port_ack !== 1'b1) begin failures++; $display("FAIL mid_ack: got %b want 1", port_ack); end
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL mid_valid: got %b want 0", mem_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL mid_ovf: got %b want 0", overflow); end
    mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
    step();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
    end
    checks++; if (port_q !== 16'h0000) begin failures++; $display("FAIL mid_stray_q: got %h want 0000", port_q); end
    checks++; if (port_ack !== 1'b1) begin failures++; $display("FAIL mid_ack_hold: got %b want 1", port_ack); end
    checks++; if (accepted.size() !== 0) begin failures++; $display("FAIL mid_no_cmd: got %0d want 0", accepted.size()); end
  endtask

  initial begin
    reset = 1'b1; port_req = 1'b0; port_a = '0; port_ds = 2'b00; port_we = 1'b0; port_d = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    test_reset();
    test_single_write();
    test_single_read();
    test_burst();
    test_overflow();
    test_simultaneous();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/toggle_port_responder.md
Name: toggle_port_responder

Overview:
- Responder end of the toggle request/acknowledge port protocol used by the ROM download path for SDRAM ports 1 and 2.
- The initiator flips port_req once per transfer and may flip it again before port_ack catches up, as the download controller does on every ioctl_wr.
- This block latches each request into a small FIFO and replays the requests in order to a valid/ready memory backend. It toggles port_ack once per finished or dropped request.
- It sits between the download controller and the SDRAM command sequencer.

Parameters:
- AW, 23, word address width (port_a, mem_addr).
- DW, 16, data width (port_d, port_q, mem_wdata, mem_rdata).
- DEPTH, 4, request FIFO entries. Must be a power of two, at least 2.

Ports:
- clk, in, 1, single clock; every signal is synchronous to it.
- reset, in, 1, synchronous, active-high.
- port_req, in, 1, request toggle; each transition is one request.
- port_ack, out, 1, acknowledge toggle; equals port_req when nothing is outstanding.
- port_a, in, AW, word address, valid in the cycle port_req transitions.
- port_ds, in, 2, byte lane strobes {hi, lo}.
- port_we, in, 1, 1 = write, 0 = read.
- port_d, in, DW, write data.
- port_q, out, DW, last read data.
- mem_valid, out, 1, backend command valid.
- mem_ready, in, 1, backend accepts the command when mem_valid and mem_ready are both high.
- mem_addr, out, AW, command address.
- mem_we, out, 1, command is a write.
- mem_be, out, 2, byte enables (copy of port_ds).
- mem_wdata, out, DW, write data.
- mem_rvalid, in, 1, read data strobe, at least 1 cycle after acceptance.
- mem_rdata, in, DW, read data.
- overflow, out, 1, sticky: a request was dropped.

Behaviour:
- Edge detect:
  - req_d registers port_req every cycle.
  - A request edge is port_req != req_d.
  - On an edge, {port_a, port_ds, port_we, port_d} from that same cycle is pushed into the FIFO.
  - One push at most per cycle.
- FIFO: circular buffer with DEPTH entries.
  - A push and a pop in the same cycle are both allowed.
  - When the FIFO is full, a push that coincides with a pop succeeds.
  - A push while full with no pop is dropped: the entry is discarded, overflow is set to 1, and the drop counts as a completion.
- Ack rule:
  - port_ack toggles on a clock edge when exactly one of {completion, drop} occurs in that cycle.
  - If both occur in the same cycle, port_ack does not change (net parity is correct).
- FSM states IDLE, ISSUE, RDWAIT:
  - IDLE: if the FIFO is not empty, pop the head into the command registers, set mem_valid = 1, go to ISSUE. The command is visible on mem_* in the cycle after the pop.
  - ISSUE: hold mem_valid and all command fields stable until mem_ready.
    - On acceptance of a write: mem_valid goes to 0, completion is raised, go to IDLE.
    - On acceptance of a read: mem_valid goes to 0, go to RDWAIT.
  - RDWAIT: on mem_rvalid, port_q <= mem_rdata, completion is raised (port_q and port_ack update on the same edge), go to IDLE.
  - mem_rvalid outside RDWAIT is ignored.
- Minimum latency from request edge to port_ack toggle, with mem_ready tied high:
  - Write: 3 cycles (push, pop/issue, accept).
  - Read: 3 cycles + read latency.
- Throughput: one command per 2 cycles at most, because IDLE is visited between commands.
- Reset (synchronous, takes priority over everything, including mid-command):
  - FIFO emptied, FSM to IDLE, mem_valid = 0, overflow = 0, port_q = 0.
  - req_d <= port_req and port_ack <= port_req, so no spurious request appears when reset is released at either req level.
  - In-flight commands are abandoned. A late mem_rvalid after reset is ignored.
- Field widths: mem_addr, mem_be and mem_wdata are passed through unmodified; no arithmetic is done on addresses.

Test Plan:
- Single write: port_req 0→1 with a=0x000123, ds=2'b01, we=1, d=0xAB12; mem_ready=1.
  - Expect mem_valid high 2 cycles after the edge, with mem_addr=0x000123, mem_be=01, mem_wdata=0xAB12.
  - Expect port_ack=1 3 cycles after the edge.
- Single read: a=0x7FFFF, we=0, backend returns 0x5AA5 3 cycles after acceptance.
  - Expect port_q=0x5AA5 and port_ack toggled on the same edge. mem_valid is high exactly 1 cycle.
- Burst: 4 toggles on consecutive cycles, writes to addresses 0..3, mem_ready stalled 10 cycles then high.
  - Expect commands issued in order 0,1,2,3.
  - Expect 4 ack toggles, with port_ack equal to port_req at the end and overflow=0.
- Overflow: DEPTH=4, mem_ready=0, 6 toggles.
  - Expect 1 command latched in the FSM, 4 entries in the FIFO, and 1 dropped.
  - Expect overflow=1 and port_ack toggled once at the drop.
  - After mem_ready=1, expect 5 more toggles, ending with port_ack==port_req.
- Simultaneous drop and completion: FIFO full and a write accepted in the same cycle as a new toggle.
  - Expect the pop to make room, so the push succeeds and nothing is dropped; verify through the FIFO count.
  - Then force a full FIFO with no pop, coincident with a read completing. Expect port_ack unchanged that cycle.
- Reset mid-read with port_req=1:
  - Expect port_ack=1, mem_valid=0, overflow=0, and no command issued after release.
  - A stray mem_rvalid after release leaves port_q=0.
